// File: rtl/display_capture.sv
// display_capture: receive-side decoder for a multiplexed 8-digit seven-segment bus.
//
// Samples the active-low one-hot digit strobe and its nibble every clock, assembles the
// eight nibbles into a 32-bit value and publishes it with a one-cycle frame strobe once
// every digit has been seen. Malformed strobes and a stalled scan are flagged.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   digit_select in   [7:0] active-low digit strobe, bit i low selects digit i
//   binary_out   in   [3:0] nibble for the strobed digit
//   clear_err    in   synchronous clear for select_error
//   count        out  [31:0] last complete value, digit i at [4i+3:4i]
//   frame_valid  out  one-cycle pulse when count is reloaded
//   changed      out  one-cycle pulse with frame_valid when the value differs
//   seen         out  [7:0] digits captured in the current incomplete frame
//   select_error out  sticky: a strobe with two or more low bits was sampled
//   stale        out  no valid strobe for TIMEOUT cycles
module display_capture #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  digit_select,
    input  logic [3:0]  binary_out,
    input  logic        clear_err,
    output logic [31:0] count,
    output logic        frame_valid,
    output logic        changed,
    output logic [7:0]  seen,
    output logic        select_error,
    output logic        stale
);

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    logic [7:0]  strobe;
    logic        is_idle;
    logic        is_valid;
    logic        is_error;

    logic [31:0] shadow_q, shadow_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  seen_q, seen_d;
    logic [15:0] idle_q, idle_d;
    logic        frame_valid_q, frame_valid_d;
    logic        changed_q, changed_d;
    logic        error_q, error_d;
    logic        stale_q, stale_d;

    // Active-high view of the strobe; a power of two means exactly one digit selected.
    assign strobe   = ~digit_select;
    assign is_idle  = (strobe == 8'h00);
    assign is_valid = !is_idle && ((strobe & (strobe - 8'd1)) == 8'h00);
    assign is_error = !is_idle && !is_valid;

    always_comb begin
        shadow_d      = shadow_q;
        count_d       = count_q;
        seen_d        = seen_q;
        idle_d        = idle_q;
        frame_valid_d = 1'b0;
        changed_d     = 1'b0;
        error_d       = error_q;
        stale_d       = stale_q;

        if (is_valid) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe[i]) begin
                    shadow_d[4*i +: 4] = binary_out;
                end
            end
            idle_d  = 16'd0;
            stale_d = 1'b0;
            // Completion uses shadow_d so this cycle's nibble is part of the frame.
            if ((seen_q | strobe) == 8'hFF) begin
                count_d       = shadow_d;
                frame_valid_d = 1'b1;
                changed_d     = (shadow_d != count_q);
                seen_d        = 8'h00;
            end else begin
                seen_d = seen_q | strobe;
            end
        end else begin
            if (idle_q != TimeoutVal) begin
                idle_d = idle_q + 16'd1;
            end
            if (is_error) begin
                seen_d = 8'h00;
            end
            // Stale rises on the edge the counter lands on TIMEOUT and holds while saturated.
            if (idle_d == TimeoutVal) begin
                stale_d = 1'b1;
                seen_d  = 8'h00;
            end
        end

        // An error sample wins over a simultaneous clear.
        if (is_error) begin
            error_d = 1'b1;
        end else if (clear_err) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_q      <= 32'h0;
            count_q       <= 32'h0;
            seen_q        <= 8'h00;
            idle_q        <= 16'd0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            error_q       <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            count_q       <= count_d;
            seen_q        <= seen_d;
            idle_q        <= idle_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
            error_q       <= error_d;
            stale_q       <= stale_d;
        end
    end

    assign count        = count_q;
    assign frame_valid  = frame_valid_q;
    assign changed      = changed_q;
    assign seen         = seen_q;
    assign select_error = error_q;
    assign stale        = stale_q;

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture: self-checking bench for display_capture (TIMEOUT = 4).
// Table-driven frames, hand-written corner sequences and randomized traffic, all
// compared each cycle against a digit-array reference model.
module tb_display_capture;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  digit_select;
    logic [3:0]  binary_out;
    logic        clear_err;
    logic [31:0] count;
    logic        frame_valid;
    logic        changed;
    logic [7:0]  seen;
    logic        select_error;
    logic        stale;

    int n_checks;
    int n_fail;

    display_capture #(
        .TIMEOUT(TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .digit_select (digit_select),
        .binary_out   (binary_out),
        .clear_err    (clear_err),
        .count        (count),
        .frame_valid  (frame_valid),
        .changed      (changed),
        .seen         (seen),
        .select_error (select_error),
        .stale        (stale)
    );

    always #5 clock = ~clock;

    // Reference model: one nibble per digit, a set of seen digits, an idle run length.
    logic [3:0]  m_shadow [8];
    logic [7:0]  m_seen;
    int          m_idle;
    logic [31:0] m_count;
    logic        m_fv;
    logic        m_ch;
    logic        m_err;
    logic        m_stale;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) m_shadow[k] = 4'h0;
        m_seen  = 8'h00;
        m_idle  = 0;
        m_count = 32'h0;
        m_fv    = 1'b0;
        m_ch    = 1'b0;
        m_err   = 1'b0;
        m_stale = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] sel, input logic [3:0] nib,
                                       input logic clr);
        int          nlow;
        int          idx;
        logic [31:0] v;
        nlow = $countones(~sel);
        m_fv = 1'b0;
        m_ch = 1'b0;
        if (nlow == 1) begin
            idx = 0;
            for (int k = 0; k < 8; k++) if (!sel[k]) idx = k;
            m_shadow[idx] = nib;
            m_seen[idx]   = 1'b1;
            m_idle        = 0;
            m_stale       = 1'b0;
            if (m_seen == 8'hFF) begin
                v = 32'h0;
                for (int k = 0; k < 8; k++) v[4*k +: 4] = m_shadow[k];
                m_fv    = 1'b1;
                m_ch    = (v != m_count);
                m_count = v;
                m_seen  = 8'h00;
            end
        end else begin
            if (m_idle < TO) m_idle++;
            if (nlow > 1) m_seen = 8'h00;
            if (m_idle == TO) begin
                m_stale = 1'b1;
                m_seen  = 8'h00;
            end
        end
        if (nlow > 1) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endfunction

    function automatic void compare_all();
        check("count", count, m_count);
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("changed", 32'(changed), 32'(m_ch));
        check("seen", 32'(seen), 32'(m_seen));
        check("select_error", 32'(select_error), 32'(m_err));
        check("stale", 32'(stale), 32'(m_stale));
    endfunction

    // Called at a falling edge: drive, let the rising edge sample, then compare.
    task automatic step(input logic [7:0] sel, input logic [3:0] nib, input logic clr);
        digit_select = sel;
        binary_out   = nib;
        clear_err    = clr;
        @(posedge clock);
        model_step(sel, nib, clr);
        @(negedge clock);
        compare_all();
    endtask

    function automatic logic [7:0] dsel(input int d);
        logic [7:0] s;
        s    = 8'hFF;
        s[d] = 1'b0;
        return s;
    endfunction

    function automatic void check_reset_outputs(input string tag);
        check({tag, "_count"}, count, 32'h0);
        check({tag, "_fv"}, 32'(frame_valid), 32'h0);
        check({tag, "_changed"}, 32'(changed), 32'h0);
        check({tag, "_seen"}, 32'(seen), 32'h0);
        check({tag, "_err"}, 32'(select_error), 32'h0);
        check({tag, "_stale"}, 32'(stale), 32'h0);
    endfunction

    typedef struct {
        logic [7:0]  sel;
        logic [3:0]  nib;
        logic        fv;
        logic        ch;
        logic [7:0]  seen;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [16];

    int          fv_count;
    int          perm [8];
    int          j;
    int          t;
    int          r;
    logic [7:0]  rs;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b0;
        digit_select = 8'hFF;
        binary_out   = 4'h0;
        clear_err    = 1'b0;
        model_reset();

        // Two identical frames: digits 0..7 with nibbles 1..8.
        vecs[0]  = '{8'hFE, 4'h1, 1'b0, 1'b0, 8'h01, 32'h0};
        vecs[1]  = '{8'hFD, 4'h2, 1'b0, 1'b0, 8'h03, 32'h0};
        vecs[2]  = '{8'hFB, 4'h3, 1'b0, 1'b0, 8'h07, 32'h0};
        vecs[3]  = '{8'hF7, 4'h4, 1'b0, 1'b0, 8'h0F, 32'h0};
        vecs[4]  = '{8'hEF, 4'h5, 1'b0, 1'b0, 8'h1F, 32'h0};
        vecs[5]  = '{8'hDF, 4'h6, 1'b0, 1'b0, 8'h3F, 32'h0};
        vecs[6]  = '{8'hBF, 4'h7, 1'b0, 1'b0, 8'h7F, 32'h0};
        vecs[7]  = '{8'h7F, 4'h8, 1'b1, 1'b1, 8'h00, 32'h87654321};
        vecs[8]  = '{8'hFE, 4'h1, 1'b0, 1'b0, 8'h01, 32'h87654321};
        vecs[9]  = '{8'hFD, 4'h2, 1'b0, 1'b0, 8'h03, 32'h87654321};
        vecs[10] = '{8'hFB, 4'h3, 1'b0, 1'b0, 8'h07, 32'h87654321};
        vecs[11] = '{8'hF7, 4'h4, 1'b0, 1'b0, 8'h0F, 32'h87654321};
        vecs[12] = '{8'hEF, 4'h5, 1'b0, 1'b0, 8'h1F, 32'h87654321};
        vecs[13] = '{8'hDF, 4'h6, 1'b0, 1'b0, 8'h3F, 32'h87654321};
        vecs[14] = '{8'hBF, 4'h7, 1'b0, 1'b0, 8'h7F, 32'h87654321};
        vecs[15] = '{8'h7F, 4'h8, 1'b1, 1'b0, 8'h00, 32'h87654321};

        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].sel, vecs[i].nib, 1'b0);
            check($sformatf("vec%0d_fv", i), 32'(frame_valid), 32'(vecs[i].fv));
            check($sformatf("vec%0d_ch", i), 32'(changed), 32'(vecs[i].ch));
            check($sformatf("vec%0d_seen", i), 32'(seen), 32'(vecs[i].seen));
            check($sformatf("vec%0d_cnt", i), count, vecs[i].cnt);
        end

        // Malformed strobe discards the partial frame; clear_err loses to an error sample.
        for (int d = 0; d < 4; d++) step(dsel(d), 4'(9 + d), 1'b0);
        step(8'b1111_0101, 4'h0, 1'b0);
        check("err_set", 32'(select_error), 32'h1);
        check("err_seen", 32'(seen), 32'h0);
        fv_count = 0;
        for (int d = 4; d < 8; d++) begin
            step(dsel(d), 4'(9 + d), 1'b0);
            if (frame_valid) fv_count++;
        end
        check("err_no_frame", 32'(fv_count), 32'h0);
        check("err_no_count", count, 32'h87654321);
        step(8'b0011_1111, 4'h0, 1'b1);
        check("err_clr_lost", 32'(select_error), 32'h1);
        step(8'hFF, 4'h0, 1'b1);
        check("err_clr", 32'(select_error), 32'h0);

        // Stalled scan after a partial frame.
        for (int d = 0; d < 3; d++) step(dsel(d), 4'hE, 1'b0);
        for (int k = 0; k < 3; k++) step(8'hFF, 4'h0, 1'b0);
        check("stale_early", 32'(stale), 32'h0);
        check("stale_seen_hold", 32'(seen), 32'h07);
        step(8'hFF, 4'h0, 1'b0);
        check("stale_set", 32'(stale), 32'h1);
        check("stale_seen", 32'(seen), 32'h0);
        check("stale_count", count, 32'h87654321);
        step(dsel(5), 4'h3, 1'b0);
        check("stale_clear", 32'(stale), 32'h0);
        check("stale_seen_new", 32'(seen), 32'h20);

        // Start clean, then an arbitrary order with digit 3 written twice.
        step(8'h00, 4'h0, 1'b0);
        step(8'hFF, 4'h0, 1'b1);
        fv_count = 0;
        step(dsel(7), 4'h1, 1'b0); if (frame_valid) fv_count++;
        step(dsel(3), 4'hA, 1'b0); if (frame_valid) fv_count++;
        step(dsel(0), 4'h2, 1'b0); if (frame_valid) fv_count++;
        step(dsel(5), 4'h3, 1'b0); if (frame_valid) fv_count++;
        step(dsel(3), 4'hB, 1'b0); if (frame_valid) fv_count++;
        step(dsel(1), 4'h4, 1'b0); if (frame_valid) fv_count++;
        step(dsel(6), 4'h5, 1'b0); if (frame_valid) fv_count++;
        step(dsel(2), 4'h6, 1'b0); if (frame_valid) fv_count++;
        step(dsel(4), 4'h7, 1'b0); if (frame_valid) fv_count++;
        check("perm_one_frame", 32'(fv_count), 32'h1);
        check("perm_fv_last", 32'(frame_valid), 32'h1);
        check("perm_count", count, 32'h1537B642);

        // Reset in the middle of a frame.
        for (int d = 0; d < 5; d++) step(dsel(d), 4'hC, 1'b0);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        fv_count = 0;
        for (int d = 7; d > 0; d--) begin
            step(dsel(d), 4'(d), 1'b0);
            if (frame_valid) fv_count++;
        end
        check("midrst_no_early", 32'(fv_count), 32'h0);
        step(dsel(0), 4'hF, 1'b0);
        check("midrst_frame", 32'(frame_valid), 32'h1);

        // Back-to-back shuffled frames with random nibbles.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j       = $urandom_range(0, i);
                t       = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int i = 0; i < 8; i++) step(dsel(perm[i]), 4'($urandom), 1'b0);
        end

        // Mixed random traffic including malformed strobes and idle runs.
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 99);
            if (r < 65) begin
                step(dsel($urandom_range(0, 7)), 4'($urandom), ($urandom_range(0, 9) == 0));
            end else if (r < 90) begin
                step(8'hFF, 4'($urandom), ($urandom_range(0, 9) == 0));
            end else if (r < 96) begin
                rs = 8'($urandom);
                if ($countones(~rs) < 2) rs = rs & 8'hFC;
                step(rs, 4'($urandom), ($urandom_range(0, 4) == 0));
            end else begin
                for (int k = 0; k < 5; k++) step(8'hFF, 4'h0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_capture.md
# display_capture

Receive-side decoder for the multiplexed 8-digit seven-segment drive bus. It samples the active-low one-hot digit strobe and the 4-bit nibble each clock, and rebuilds the 32-bit value being displayed. It publishes that value with a one-cycle frame strobe once all eight digits have been seen. It sits beside the display driver as a loopback monitor for self-check and score readback, and flags malformed strobes and a stalled scan.

## Interface

- TIMEOUT, 256, idle cycles without a valid digit strobe before the scan is declared stale (range 2..65535).

- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- digit_select  in  8  active-low digit strobe; bit i low selects digit i. Synchronous to clock.
- binary_out  in  4  nibble for the currently strobed digit.
- clear_err  in  1  synchronous pulse that clears select_error.
- count  out  32  last complete captured value; digit i occupies [4i+3:4i].
- frame_valid  out  1  one-cycle pulse when count is updated.
- changed  out  1  one-cycle pulse, coincident with frame_valid, when the new count differs from the previous count.
- seen  out  8  digits captured in the current, incomplete frame.
- select_error  out  1  sticky flag: a strobe with two or more low bits was sampled.
- stale  out  1  no valid digit for TIMEOUT cycles.

## Operation

- Sample classification per cycle:
  - Valid: exactly one low bit, at index i.
  - Idle: 8'hFF.
  - Error: two or more low bits.
- Valid sample:
  - Write binary_out into shadow nibble i.
  - Set seen[i].
  - Reset the idle counter to 0.
  - Clear stale.
- Repeated digit within a frame: overwrite shadow nibble i; seen is unchanged.
- Frame completion: when seen OR (1<<i) equals 8'hFF on a valid sample:
  - Load count from shadow, including this cycle's nibble.
  - Pulse frame_valid.
  - Pulse changed if the loaded value differs from the previous count.
  - Clear seen to 0.
- Idle sample:
  - Shadow and seen hold.
  - The idle counter increments and saturates at TIMEOUT.
- Error sample:
  - Set select_error.
  - Clear seen to 0 (the frame is discarded).
  - The idle counter increments as for idle.
  - count is untouched.
- Idle counter reaching TIMEOUT:
  - Assert stale.
  - Clear seen.
  - count retains its last value.
  - stale holds until the next valid sample.
- clear_err clears select_error on the next edge. If an error sample occurs in the same cycle as clear_err, the error sample takes priority and select_error stays 1.
- Shadow registers are never cleared except by reset. A discarded frame leaves stale nibbles in shadow, which are overwritten before the next completion.

## Timing

- Reset values while reset is low:
  - count = 0, seen = 0, shadow = 0.
  - frame_valid = 0, changed = 0, select_error = 0, stale = 0.
  - Idle counter = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: the frame_valid, changed, count and seen updates are visible on the edge after the completing sample (1 cycle).
- Minimum frame period is 8 cycles, one strobe per cycle, with no bubbles required. Back-to-back frames produce frame_valid every 8 cycles.
- stale asserts on the edge where the idle counter first equals TIMEOUT, i.e. TIMEOUT cycles after the last valid sample.
- Reset asserted mid-frame discards the partial frame. The first valid sample after release starts a new frame.
- Digit order is irrelevant; any permutation of all 8 digits completes a frame.

## Test plan

- Reset, then strobe digits 0..7 in order with nibbles 1..8 -> frame_valid and changed pulse once, 1 cycle after digit 7; count = 32'h87654321; seen = 0.
- Repeat the identical frame immediately -> frame_valid pulses 8 cycles later; changed stays 0; count unchanged.
- After digits 0..3, sample 8'b11110101 -> select_error = 1 and seen = 0. Completing digits 4..7 gives no frame_valid. clear_err applied together with a second error sample -> select_error stays 1; clear_err alone -> select_error = 0.
- Partial frame (digits 0..2), then 8'hFF held for TIMEOUT = 4 cycles -> stale = 1 on the 4th idle edge; seen = 0; count retained. The next valid strobe clears stale.
- Strobe in order 7,3,0,5,1,6,2,4, with digit 3 strobed twice (nibbles A then B) -> a single frame_valid; count nibble 3 = B.
- Drop reset low mid-frame after 5 digits, then release -> all outputs 0. Frame_valid occurs only after 8 fresh digits.
